m_lsu: RTL and testbench

Memory-stage load/store unit: the initiator side of the data-memory port. It takes one load or store per instruction from the M-stage pipeline register and issues a single word-aligned request with byte enables over a valid/ready handshake. It stalls the pipeline until the memory responds, then sign- or zero-extends the returned sub-word for the writeback path. Misaligned or out-of-range accesses are trapped before any memory access is issued.

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/m_lsu_ext.sv | 34 +++
 rtl/m_lsu.sv | 124 ++++++++++++
 tb/tb_m_lsu.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit:
// op encodings, store-bit index and FSM states.
package lsu_pkg;

  localparam int ST_BIT = 3;

  localparam logic [3:0] OP_NONE = 4'h0;
  localparam logic [3:0] OP_LW   = 4'h1;
  localparam logic [3:0] OP_LH   = 4'h2;
  localparam logic [3:0] OP_LHU  = 4'h3;
  localparam logic [3:0] OP_LB   = 4'h4;
  localparam logic [3:0] OP_LBU  = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_SH   = 4'hA;
  localparam logic [3:0] OP_SB   = 4'hB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/m_lsu_ext.sv
// Lane select plus sign/zero extension of a loaded word.
// Shared with the writeback bypass path.
module lsu_ext
  import lsu_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] word_i,
  output logic [31:0] res_o
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = 8'h0;
    unique case (lane_i)
      2'd0: b = word_i[7:0];
      2'd1: b = word_i[15:8];
      2'd2: b = word_i[23:16];
      2'd3: b = word_i[31:24];
    endcase
    h = lane_i[1] ? word_i[31:16] : word_i[15:0];
    res_o = word_i;
    case (op_i)
      OP_LB:   res_o = {{24{b[7]}}, b};
      OP_LBU:  res_o = {24'h0, b};
      OP_LH:   res_o = {{16{h[15]}}, h};
      OP_LHU:  res_o = {16'h0, h};
      default: res_o = word_i;
    endcase
  end

endmodule

// File: rtl/m_lsu.sv
// M-stage load/store unit: single outstanding word-aligned
// request with byte enables, pipeline stall and load extension.
module m_lsu
  import lsu_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic        stall,
  output logic        rdata_valid,
  output logic [31:0] rdata,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic [31:0] exc_pc,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  state_t      state_q;
  logic [3:0]  op_q;
  logic [1:0]  lane_q;
  logic [31:0] ext;

  logic        is_ld, is_st, is_w, is_h;
  logic        bad, take;
  logic [3:0]  be_d;
  logic [31:0] wd_d;

  always_comb begin
    is_ld = (op == OP_LW) || (op == OP_LH) || (op == OP_LHU)
         || (op == OP_LB) || (op == OP_LBU);
    is_st = (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    is_w  = (op == OP_LW) || (op == OP_SW);
    is_h  = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    bad   = (is_w && (addr[1:0] != 2'b00))
         || (is_h && addr[0])
         || (addr >= ADDR_LIMIT);
    take  = !reset && (state_q == IDLE) && req_valid
         && (is_ld || is_st);
  end

  assign exc_adel = take && is_ld && bad;
  assign exc_ades = take && is_st && bad;
  assign exc_pc   = (exc_adel || exc_ades) ? pc : 32'h0;
  assign stall    = (take && !bad) || (state_q == BUSY);

  always_comb begin
    be_d = 4'b0001 << addr[1:0];
    wd_d = {4{wdata[7:0]}};
    if (is_w) begin
      be_d = 4'b1111;
      wd_d = wdata;
    end else if (is_h) begin
      be_d = addr[1] ? 4'b1100 : 4'b0011;
      wd_d = {2{wdata[15:0]}};
    end
  end

  lsu_ext u_ext (
    .op_i   (op_q),
    .lane_i (lane_q),
    .word_i (mem_rdata),
    .res_o  (ext)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= OP_NONE;
      lane_q      <= 2'b00;
      rdata_valid <= 1'b0;
      rdata       <= 32'h0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_be      <= 4'h0;
      mem_addr    <= 32'h0;
      mem_wdata   <= 32'h0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (take && !bad) begin
            state_q   <= BUSY;
            op_q      <= op;
            lane_q    <= addr[1:0];
            mem_req   <= 1'b1;
            mem_we    <= is_st;
            mem_be    <= be_d;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_wdata <= wd_d;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            state_q     <= DONE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_be      <= 4'h0;
            rdata_valid <= 1'b1;
            if (!op_q[ST_BIT])
              rdata <= ext;
          end
        end
        DONE: begin
          // pipeline advances on this edge; req_valid is stale here
          state_q     <= IDLE;
          rdata_valid <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m_lsu.sv
// Self-checking bench for m_lsu with a load-result scoreboard.
module tb_m_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [3:0]  op;
  logic [31:0] addr, wdata, pc;
  logic        stall, rdata_valid;
  logic [31:0] rdata;
  logic        exc_adel, exc_ades;
  logic [31:0] exc_pc;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  m_lsu dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .op(op),
    .addr(addr), .wdata(wdata), .pc(pc), .stall(stall),
    .rdata_valid(rdata_valid), .rdata(rdata),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .exc_pc(exc_pc),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] model(input logic [3:0] o,
                                        input logic [1:0] a,
                                        input logic [31:0] w);
    logic [31:0] s;
    s = w >> (8 * a);
    case (o)
      OP_LB:   return {{24{s[7]}}, s[7:0]};
      OP_LBU:  return {24'h0, s[7:0]};
      OP_LH:   begin s = w >> (16 * a[1]); return {{16{s[15]}}, s[15:0]}; end
      OP_LHU:  begin s = w >> (16 * a[1]); return {16'h0, s[15:0]}; end
      default: return w;
    endcase
  endfunction

  // one legal access; k = cycle in which memory answers
  task automatic do_op(input string nm, input logic [3:0] o,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] word, input int k,
                       input bit hold, input logic [3:0] xbe,
                       input logic [31:0] xwd);
    logic [31:0] xr;
    logic [73:0] got, want;
    if (o[3]) xr = last_rd;
    else begin xr = model(o, a[1:0], word); last_rd = xr; end
    exp_q.push_back(xr);
    @(posedge clk); #1;
    req_valid = 1'b1; op = o; addr = a; wdata = wd;
    pc = 32'h1000 + a;
    @(negedge clk);
    total++;
    if ({stall, mem_req, exc_adel, exc_ades} !== 4'b1000) begin
      $display("FAIL %s accept: got %b want 1000", nm,
               {stall, mem_req, exc_adel, exc_ades});
      bad++;
    end
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    for (int c = 1; c <= k; c++) begin
      if (c == k) begin mem_ready = 1'b1; mem_rdata = word; end
      @(negedge clk);
      got  = {mem_req, mem_we, mem_be, mem_addr, mem_wdata, stall};
      want = {1'b1, o[3], xbe, {a[31:2], 2'b00}, xwd, 1'b1};
      total++;
      if (got !== want) begin
        $display("FAIL %s busy c%0d: got %h want %h", nm, c, got, want);
        bad++;
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b0; mem_rdata = $urandom;
    @(negedge clk);
    total++;
    if ({rdata_valid, stall, mem_req} !== 3'b100) begin
      $display("FAIL %s done: got %b want 100", nm,
               {rdata_valid, stall, mem_req});
      bad++;
    end
    if (rdata_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL %s scoreboard empty", nm);
        bad++;
      end else begin
        xr = exp_q.pop_front();
        if (rdata !== xr) begin
          $display("FAIL %s rdata: got %h want %h", nm, rdata, xr);
          bad++;
        end
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({rdata_valid, mem_req, stall} !== 3'b000) begin
      $display("FAIL %s after: got %b want 000", nm,
               {rdata_valid, mem_req, stall});
      bad++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; op = OP_NONE;
    addr = 0; wdata = 0; pc = 0; mem_ready = 1'b0; mem_rdata = 0;
    last_rd = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    total++;
    if ({stall, rdata_valid, mem_req, mem_we, exc_adel, exc_ades,
         mem_be, rdata, mem_addr, mem_wdata, exc_pc} !== '0) begin
      $display("FAIL reset: got nonzero outputs rv=%b req=%b be=%h rd=%h",
               rdata_valid, mem_req, mem_be, rdata);
      bad++;
    end
  endtask

  task automatic test_loads();
    do_op("lw", OP_LW, 32'h10, 0, 32'hDEADBEEF, 3, 0, 4'b1111, 32'h0);
    do_op("lb", OP_LB, 32'h13, 0, 32'h80FF7F01, 1, 0, 4'b1000, 32'h0);
    do_op("lbu", OP_LBU, 32'h13, 0, 32'h80FF7F01, 2, 0, 4'b1000, 32'h0);
    do_op("lh", OP_LH, 32'h12, 0, 32'h8001_1234, 1, 0, 4'b1100, 32'h0);
    do_op("lhu", OP_LHU, 32'h3FFE, 0, 32'h8001_F234, 1, 0, 4'b1100, 32'h0);
    do_op("lb1", OP_LB, 32'h21, 0, 32'h0000_7F00, 1, 0, 4'b0010, 32'h0);
  endtask

  task automatic test_stores();
    do_op("sh", OP_SH, 32'h22, 32'h1234ABCD, 32'h0, 2, 0,
          4'b1100, 32'hABCDABCD);
    do_op("sb", OP_SB, 32'h1, 32'h0000_0055, 32'h0, 1, 0,
          4'b0010, 32'h55555555);
    do_op("sw", OP_SW, 32'h3FFC, 32'hCAFEF00D, 32'h0, 1, 0,
          4'b1111, 32'hCAFEF00D);
  endtask

  task automatic test_exc();
    logic [3:0]  ops [3] = '{OP_LW, OP_SB, OP_LH};
    logic [31:0] adr [3] = '{32'h6, 32'h4000, 32'h3};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b1; op = ops[i]; addr = adr[i];
      pc = 32'h200 + 32'(i);
      #1;
      total++;
      if ({exc_adel, exc_ades, stall, exc_pc} !==
          {!ops[i][3], ops[i][3], 1'b0, 32'h200 + 32'(i)}) begin
        $display("FAIL exc%0d: got %b%b%b pc=%h", i,
                 exc_adel, exc_ades, stall, exc_pc);
        bad++;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      total++;
      if ({mem_req, stall, exc_adel, exc_ades} !== 4'b0000) begin
        $display("FAIL exc%0d after: got %b want 0000", i,
                 {mem_req, stall, exc_adel, exc_ades});
        bad++;
      end
    end
  endtask

  task automatic test_reset_busy();
    @(posedge clk); #1;
    req_valid = 1'b1; op = OP_LW; addr = 32'h40;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    total++;
    if (mem_req !== 1'b1) begin
      $display("FAIL rstbusy req: got %b want 1", mem_req);
      bad++;
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    last_rd = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if ({mem_req, rdata_valid, stall} !== 3'b000) begin
        $display("FAIL rstbusy c%0d: got %b want 000", c,
                 {mem_req, rdata_valid, stall});
        bad++;
      end
    end
    do_op("sw_after_rst", OP_SW, 32'h44, 32'h0BAD_F00D, 32'h0, 2, 0,
          4'b1111, 32'h0BAD_F00D);
  endtask

  task automatic test_spurious();
    @(posedge clk); #1;
    mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    total++;
    if ({mem_req, rdata_valid, stall} !== 3'b000) begin
      $display("FAIL idle_ready: got %b want 000",
               {mem_req, rdata_valid, stall});
      bad++;
    end
    do_op("hold_lbu", OP_LBU, 32'h30, 0, 32'h0000_00F1, 2, 1,
          4'b0001, 32'h0);
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_exc();
    test_reset_busy();
    test_spurious();
    total++;
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard leftover: got %0d want 0", exp_q.size());
      bad++;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
